// File: rtl/traffic_cmd_rx_if.sv
// Command receiver bus: gated serial input towards the receiver and the
// decoded command port that feeds the traffic light controller.
interface traffic_cmd_rx_if;
    logic        data_i;
    logic        data_val_i;
    logic [2:0]  cmd_type_o;
    logic [15:0] cmd_data_o;
    logic        cmd_valid_o;
    logic        err_o;
    logic        busy_o;

    // Serial source side: drives bits, observes decoded commands.
    modport master (
        output data_i,
        output data_val_i,
        input  cmd_type_o,
        input  cmd_data_o,
        input  cmd_valid_o,
        input  err_o,
        input  busy_o
    );

    // Receiver side: samples bits, drives decoded commands.
    modport slave (
        input  data_i,
        input  data_val_i,
        output cmd_type_o,
        output cmd_data_o,
        output cmd_valid_o,
        output err_o,
        output busy_o
    );
endinterface

// File: rtl/traffic_cmd_rx.sv
// Serial command receiver: hunts for a sync word, captures a 3-bit type and
// 16-bit data word MSB-first, checks even parity and type legality, and
// presents legal commands as a single-cycle pulse on registered outputs.
module traffic_cmd_rx #(
    parameter int                SYNC_W         = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD      = 8'hA5,
    parameter int                TIMEOUT_CYCLES = 64,
    parameter int                MAX_CMD_TYPE   = 5
) (
    input  logic            clk_i,
    input  logic            srst_i,
    traffic_cmd_rx_if.slave bus
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] TYPE   = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
    localparam logic [1:0] PARITY = 2'd3;

    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]     MAX_TYPE = 3'(MAX_CMD_TYPE);

    // Even parity across type, data and the parity bit itself.
    function automatic logic frame_parity_ok(input logic [2:0]  t,
                                             input logic [15:0] d,
                                             input logic        p);
        return (^{t, d, p}) == 1'b0;
    endfunction

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [SYNC_W-1:0] sync_r;
    logic [SYNC_W-1:0] sync_cand_s;
    logic              sync_hit_s;
    logic [4:0]        bit_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              tmo_hit_s;
    logic [2:0]        type_sh_r;
    logic [15:0]       data_sh_r;
    logic              accept_s;
    logic              reject_s;
    logic              timeout_s;
    logic [2:0]        cmd_type_r;
    logic [15:0]       cmd_data_r;
    logic              cmd_valid_r;
    logic              err_r;
    logic              busy_r;

    assign sync_cand_s = {sync_r[SYNC_W-2:0], bus.data_i};
    assign sync_hit_s  = bus.data_val_i && (sync_cand_s == SYNC_WORD);
    assign tmo_hit_s   = !bus.data_val_i && (tmo_cnt_r == TMO_LAST);

    // Frame sequencing: next state plus accept / reject / timeout decisions.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            HUNT: begin
                if (sync_hit_s) begin
                    state_nxt_s = TYPE;
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            TYPE: begin
                if (bus.data_val_i) begin
                    if (bit_cnt_r == 5'd2) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = TYPE;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt_s = HUNT;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = TYPE;
                end
            end
            DATA: begin
                if (bus.data_val_i) begin
                    if (bit_cnt_r == 5'd15) begin
                        state_nxt_s = PARITY;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt_s = HUNT;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (bus.data_val_i) begin
                    state_nxt_s = HUNT;
                    if (frame_parity_ok(type_sh_r, data_sh_r, bus.data_i) &&
                        (type_sh_r <= MAX_TYPE)) begin
                        accept_s = 1'b1;
                    end else begin
                        reject_s = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt_s = HUNT;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            default: begin
                state_nxt_s = HUNT;
            end
        endcase
    end

    // State register and registered busy flag (high outside HUNT).
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_r <= HUNT;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != HUNT);
        end
    end

    // Sync hunting shift register; cleared on a hit so the next frame must resend it.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync_r <= '0;
        end else if ((state_r == HUNT) && bus.data_val_i) begin
            if (sync_hit_s) begin
                sync_r <= '0;
            end else begin
                sync_r <= sync_cand_s;
            end
        end
    end

    // Field bit counter (restarts on every state change) and inactivity timer.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            bit_cnt_r <= 5'd0;
            tmo_cnt_r <= '0;
        end else begin
            if (state_nxt_s != state_r) begin
                bit_cnt_r <= 5'd0;
            end else if (bus.data_val_i && ((state_r == TYPE) || (state_r == DATA))) begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end
            if ((state_nxt_s == HUNT) || bus.data_val_i) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
        end
    end

    // Shadow capture of type and data; stale contents are dropped at each new sync.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            type_sh_r <= 3'd0;
            data_sh_r <= 16'd0;
        end else if ((state_r == HUNT) && sync_hit_s) begin
            type_sh_r <= 3'd0;
            data_sh_r <= 16'd0;
        end else if ((state_r == TYPE) && bus.data_val_i) begin
            type_sh_r <= {type_sh_r[1:0], bus.data_i};
        end else if ((state_r == DATA) && bus.data_val_i) begin
            data_sh_r <= {data_sh_r[14:0], bus.data_i};
        end
    end

    // Command outputs: load only on acceptance; valid and error are one-cycle pulses.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cmd_type_r  <= 3'd0;
            cmd_data_r  <= 16'd0;
            cmd_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            cmd_valid_r <= accept_s;
            err_r       <= reject_s | timeout_s;
            if (accept_s) begin
                cmd_type_r <= type_sh_r;
                cmd_data_r <= data_sh_r;
            end
        end
    end

    assign bus.cmd_type_o  = cmd_type_r;
    assign bus.cmd_data_o  = cmd_data_r;
    assign bus.cmd_valid_o = cmd_valid_r;
    assign bus.err_o       = err_r;
    assign bus.busy_o      = busy_r;

endmodule

// File: tb/tb_traffic_cmd_rx.sv
// Self-checking bench for traffic_cmd_rx: directed frames from the test plan
// followed by randomized frames, checked against a frame-level reference.
module tb_traffic_cmd_rx;

    logic clk_i = 1'b0;
    logic srst_i;

    traffic_cmd_rx_if bus();

    traffic_cmd_rx dut (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int exp_vld = 0;
    int exp_err = 0;
    int vld_seen = 0;
    int err_seen = 0;
    int both_seen = 0;
    logic [2:0]  exp_type = 3'd0;
    logic [15:0] exp_data = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Pulse monitor: each high cycle of a pulse output counts once.
    always @(negedge clk_i) begin
        if (bus.cmd_valid_o === 1'b1) vld_seen <= vld_seen + 1;
        if (bus.err_o === 1'b1) err_seen <= err_seen + 1;
        if ((bus.cmd_valid_o === 1'b1) && (bus.err_o === 1'b1)) both_seen <= both_seen + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Drive one cycle of input; returns right after the sampling edge.
    task automatic step(input logic v, input logic b);
        @(negedge clk_i);
        bus.data_val_i = v;
        bus.data_i     = b;
        @(posedge clk_i);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'($urandom));
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) step(1'b0, 1'($urandom));
        step(1'b1, b);
    endtask

    // True if the garbage followed by the sync word would sync before the final bit.
    function automatic bit early_sync(input logic [15:0] g, input int glen);
        logic [7:0] win;
        logic [7:0] sw;
        win = 8'h00;
        sw  = 8'hA5;
        for (int i = glen - 1; i >= 0; i--) begin
            win = {win[6:0], g[i]};
            if (win == 8'hA5) return 1'b1;
        end
        for (int i = 7; i >= 1; i--) begin
            win = {win[6:0], sw[i]};
            if (win == 8'hA5) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Full frame: garbage, sync, type, data, parity. cut_at aborts with a
    // 64-cycle silence after that payload bit; long_at puts a 63-cycle gap before it.
    task automatic send_frame(input logic [2:0] t, input logic [15:0] d, input logic p,
                              input int maxgap, input int cut_at, input int long_at,
                              input logic [15:0] g, input int glen);
        logic [7:0]  sw;
        logic [19:0] pl;
        logic        ok;
        int          gap;
        sw = 8'hA5;
        pl = {t, d, p};
        for (int i = glen - 1; i >= 0; i--) send_bit(g[i], int'($urandom_range(maxgap, 0)));
        for (int i = 7; i >= 0; i--) send_bit(sw[i], int'($urandom_range(maxgap, 0)));
        #1;
        chk("busy_after_sync", 32'(bus.busy_o), 32'd1);
        for (int i = 0; i < 20; i++) begin
            gap = (i == long_at) ? 63 : int'($urandom_range(maxgap, 0));
            send_bit(pl[19-i], gap);
            if (i == cut_at) begin
                repeat (63) step(1'b0, 1'($urandom));
                #1;
                chk("tmo_busy_hold", 32'(bus.busy_o), 32'd1);
                chk("tmo_err_early", 32'(bus.err_o), 32'd0);
                step(1'b0, 1'($urandom));
                #1;
                chk("tmo_err", 32'(bus.err_o), 32'd1);
                chk("tmo_busy", 32'(bus.busy_o), 32'd0);
                chk("tmo_valid", 32'(bus.cmd_valid_o), 32'd0);
                chk("tmo_type_hold", 32'(bus.cmd_type_o), 32'(exp_type));
                chk("tmo_data_hold", 32'(bus.cmd_data_o), 32'(exp_data));
                exp_err++;
                return;
            end
        end
        #1;
        ok = ((^{t, d, p}) == 1'b0) && (t <= 3'd5);
        if (ok) begin
            exp_type = t;
            exp_data = d;
            exp_vld++;
        end else begin
            exp_err++;
        end
        chk("cmd_valid", 32'(bus.cmd_valid_o), 32'(ok));
        chk("err", 32'(bus.err_o), 32'(!ok));
        chk("cmd_type", 32'(bus.cmd_type_o), 32'(exp_type));
        chk("cmd_data", 32'(bus.cmd_data_o), 32'(exp_data));
        chk("busy_end", 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        logic [15:0] g;
        int          glen;
        logic [2:0]  t;
        logic [15:0] d;
        logic        p;
        logic [19:0] pl;
        logic [7:0]  sw;

        srst_i         = 1'b1;
        bus.data_val_i = 1'b0;
        bus.data_i     = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(bus.cmd_valid_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_type", 32'(bus.cmd_type_o), 32'd0);
        chk("rst_data", 32'(bus.cmd_data_o), 32'd0);
        @(negedge clk_i);
        srst_i = 1'b0;
        idle(2);

        // Basic legal frame, then the same frame with bad parity, then illegal types.
        send_frame(3'd3, 16'h0014, 1'b0, 0, -1, -1, 16'h0, 0);
        send_frame(3'd3, 16'h0014, 1'b1, 0, -1, -1, 16'h0, 0);
        idle(2);
        send_frame(3'd7, 16'h0000, 1'b1, 0, -1, -1, 16'h0, 0);
        send_frame(3'd6, 16'h0000, 1'b0, 0, -1, -1, 16'h0, 0);

        // Gapped frame, then timeout after the 5th data bit, then recovery.
        send_frame(3'd4, 16'h1234, ^{3'd4, 16'h1234}, 10, -1, -1, 16'h0, 0);
        send_frame(3'd0, 16'h00FF, 1'b0, 0, 7, -1, 16'h0, 0);
        send_frame(3'd0, 16'h0F0F, 1'b0, 0, -1, -1, 16'h0, 0);
        send_frame(3'd5, 16'hA5A5, ^{3'd5, 16'hA5A5}, 2, -1, 10, 16'h0, 0);

        // Garbage 1,0,1,1 ahead of the sync word.
        send_frame(3'd1, 16'hFFFF, 1'b1, 0, -1, -1, 16'b1011, 4);

        // Reset in the middle of the data field.
        sw = 8'hA5;
        pl = {3'd6, 16'hC3C3, 1'b0};
        for (int i = 7; i >= 0; i--) send_bit(sw[i], 0);
        for (int i = 0; i < 11; i++) send_bit(pl[19-i], 1);
        @(negedge clk_i);
        srst_i         = 1'b1;
        bus.data_val_i = 1'b0;
        @(posedge clk_i);
        #1;
        exp_type = 3'd0;
        exp_data = 16'd0;
        chk("midrst_busy", 32'(bus.busy_o), 32'd0);
        chk("midrst_type", 32'(bus.cmd_type_o), 32'd0);
        chk("midrst_data", 32'(bus.cmd_data_o), 32'd0);
        chk("midrst_valid", 32'(bus.cmd_valid_o), 32'd0);
        @(negedge clk_i);
        srst_i = 1'b0;
        send_frame(3'd2, 16'hBEEF, ^{3'd2, 16'hBEEF}, 0, -1, -1, 16'h0, 0);

        // Randomized frames, including back-to-back ones with no idle cycle.
        for (int n = 0; n < 40; n++) begin
            t = 3'($urandom);
            d = 16'($urandom);
            p = (^{t, d}) ^ ($urandom_range(3, 0) == 0);
            do begin
                g    = 16'($urandom);
                glen = int'($urandom_range(8, 0));
            end while (early_sync(g, glen));
            send_frame(t, d, p, int'($urandom_range(3, 0)), -1, -1, g, glen);
        end

        idle(4);
        chk("valid_pulses", 32'(vld_seen), 32'(exp_vld));
        chk("err_pulses", 32'(err_seen), 32'(exp_err));
        chk("valid_err_overlap", 32'(both_seen), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
